ping_pong_counter_mm: RTL and testbench
=======================================

Name: ping_pong_counter_mm

Overview:
Parameterised multi-mode successor to the team's ping-pong counter.
- Counts between run-time bounds min/max with a programmable step.
- Four modes: ping-pong, wrap-up, wrap-down, hold.
- Supports direction flip, parallel load, and range-error flagging.
- Sits in the lab display/sequencing datapath and feeds 7-segment and LED drivers.

Parameters:
WIDTH, 4, bit width of out, min, max, step and load_val.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  count enable; when 0, out and direction hold (load still honoured).
mode  input  2  00 ping-pong, 01 wrap-up, 10 wrap-down, 11 hold.
min  input  WIDTH  lower bound, inclusive.
max  input  WIDTH  upper bound, inclusive.
step  input  WIDTH  increment magnitude; 0 means hold.
flip  input  1  reverse direction; sampled only when enable=1 and mode=00.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  value written on load.
out  output  WIDTH  registered count.
direction  output  1  registered direction; 1 = up, 0 = down.
at_bound  output  1  combinational; 1 when range is valid and (out==min or out==max).
range_err  output  1  combinational; 1 when min>=max.

Behaviour:
- Reset (asynchronous, immediate, independent of clk):
  - out=0, direction=1.
  - at_bound and range_err follow their combinational definitions.
- Per-edge priority, highest first:
  1. load
  2. enable=0
  3. range_err
  4. out outside [min,max]
  5. mode=11 or step=0
  6. flip
  7. normal count
- load: out<=load_val, direction<=1; applies regardless of enable.
- enable=0: out and direction hold.
- range_err=1: out and direction hold until the range becomes valid.
- Out of range (out<min or out>max): out<=min, direction<=1 (recentre), in any mode.
- Hold (mode=11 or step=0): out and direction hold.
- Saturating step arithmetic, computed with differences so nothing overflows WIDTH:
  - up(x) = (max-x <= step) ? max : x+step
  - dn(x) = (x-min <= step) ? min : x-step
- Mode 00, ping-pong:
  - dir=1, out!=max: out<=up(out).
  - dir=1, out==max: direction<=0, out<=dn(max).
  - dir=0, out!=min: out<=dn(out).
  - dir=0, out==min: direction<=1, out<=up(min).
  - Each bound appears for exactly one cycle per sweep.
- flip (mode 00 only, after the range checks pass): direction<=~direction, and out moves one step in the new direction using up/dn.
- Mode 01, wrap-up:
  - direction<=1.
  - out<=(out==max) ? min : up(out).
  - flip is ignored.
- Mode 10, wrap-down:
  - direction<=0.
  - out<=(out==min) ? max : dn(out).
  - flip is ignored.
- Mode change takes effect on the next enabled edge with no extra latency; ping-pong resumes from the current registered direction.
- Bound changes mid-count:
  - Take effect on the next edge.
  - If out is now outside the range, the recentre rule applies.
  - If out equals a new bound, the normal reverse/wrap rule applies.
- Latency: one clock from input change to out/direction update.
- No combinational path from inputs to out or direction.

Test Plan:
1. Ping-pong, step 1: rst pulse, min=3, max=12, step=1, mode=00, enable=1.
   - out: 0 -> 3,4,...,12,11,...,3,4.
   - direction falls on the edge where out becomes 11; rises on the edge where out becomes 4.
2. Ping-pong, step 4: min=3, max=12, step=4.
   - out: 3,7,11,12,8,4,3,7.
   - at_bound=1 exactly while out is 3 or 12.
3. Flip and enable: counting up at out=6, pulse flip for one cycle.
   - Next out=5, direction=0, then 4, 3, 4.
   - With enable=0, flip has no effect and out holds.
4. Wrap-up, WIDTH overflow: mode=01, min=0, max=15, step=3, from out=12.
   - out: 15,0,3. No overflow past 15.
   - mode=10 from out=2, step=3: 0,15,12.
5. Invalid range and recovery: min=8, max=2.
   - range_err=1; out holds for 5 cycles.
   - Then min=7, max=15 with out=3: next out=7, direction=1.
   - Then min=7, max=8: out alternates 7,8,7.
6. Reset and load: assert rst between clock edges mid-count.
   - out=0 and direction=1 before the next edge.
   - Release rst, enable=0, load=1, load_val=9: out=9 on the next edge, still holding afterward.

Source files
------------

// File: rtl/ping_pong_counter_mm.sv
// Multi-mode bounded counter: ping-pong, wrap-up, wrap-down and hold.
// Run-time bounds and step, with saturating steps and recentring when out leaves the range.
//
// state  | meaning
// DIR_DN | counting toward min
// DIR_UP | counting toward max
module ping_pong_counter_mm #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] step,
  input  logic             flip,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             direction,
  output logic             at_bound,
  output logic             range_err
);

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

  localparam logic [1:0] MODE_PP      = 2'b00;
  localparam logic [1:0] MODE_WRAP_UP = 2'b01;
  localparam logic [1:0] MODE_WRAP_DN = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  dir_t             dir_q, dir_d;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_up, out_dn, max_dn, min_up;
  logic             in_range;

  assign range_err = (min >= max);
  assign at_bound  = !range_err && ((out == min) || (out == max));
  assign in_range  = (out >= min) && (out <= max);
  assign direction = dir_q;

  // Differences only; operands are guaranteed ordered whenever these are used.
  assign out_up = ((max - out) <= step) ? max : out + step;
  assign out_dn = ((out - min) <= step) ? min : out - step;
  assign max_dn = ((max - min) <= step) ? min : max - step;
  assign min_up = ((max - min) <= step) ? max : min + step;

  always_comb begin
    out_d = out;
    dir_d = dir_q;
    if (load) begin
      out_d = load_val;
      dir_d = DIR_UP;
    end else if (enable && !range_err) begin
      if (!in_range) begin
        out_d = min;
        dir_d = DIR_UP;
      end else if ((mode != MODE_HOLD) && (step != '0)) begin
        case (mode)
          MODE_PP: begin
            if (flip) begin
              if (dir_q == DIR_UP) begin
                dir_d = DIR_DN;
                out_d = out_dn;
              end else begin
                dir_d = DIR_UP;
                out_d = out_up;
              end
            end else if (dir_q == DIR_UP) begin
              if (out == max) begin
                dir_d = DIR_DN;
                out_d = max_dn;
              end else begin
                out_d = out_up;
              end
            end else begin
              if (out == min) begin
                dir_d = DIR_UP;
                out_d = min_up;
              end else begin
                out_d = out_dn;
              end
            end
          end
          MODE_WRAP_UP: begin
            dir_d = DIR_UP;
            out_d = (out == max) ? min : out_up;
          end
          MODE_WRAP_DN: begin
            dir_d = DIR_DN;
            out_d = (out == min) ? max : out_dn;
          end
          default: begin
            out_d = out;
            dir_d = dir_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out   <= '0;
      dir_q <= DIR_UP;
    end else begin
      out   <= out_d;
      dir_q <= dir_d;
    end
  end

endmodule

// File: tb/tb_ping_pong_counter_mm.sv
// Directed bench for ping_pong_counter_mm: an integer reference model feeds a
// scoreboard queue each cycle, plus literal sequences for the key scenarios.
module tb_ping_pong_counter_mm;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] min, max, step;
  logic       flip, load;
  logic [3:0] load_val;
  logic [3:0] out;
  logic       direction, at_bound, range_err;

  ping_pong_counter_mm #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .min(min), .max(max), .step(step), .flip(flip),
    .load(load), .load_val(load_val),
    .out(out), .direction(direction), .at_bound(at_bound), .range_err(range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] out;
    logic       dir;
    logic       ab;
    logic       re;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] m_out;
  logic       m_dir;
  int         seq[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sat_up(logic [3:0] x);
    int s;
    s = int'(x) + int'(step);
    return (s >= int'(max)) ? max : 4'(s);
  endfunction

  function automatic logic [3:0] sat_dn(logic [3:0] x);
    int d;
    d = int'(x) - int'(step);
    return (d <= int'(min)) ? min : 4'(d);
  endfunction

  task automatic model_step();
    if (load) begin
      m_out = load_val;
      m_dir = 1'b1;
    end else if (!enable || (min >= max)) begin
      m_out = m_out;
    end else if ((m_out < min) || (m_out > max)) begin
      m_out = min;
      m_dir = 1'b1;
    end else if ((mode == 2'b11) || (step == 4'd0)) begin
      m_out = m_out;
    end else if (mode == 2'b00) begin
      if (flip) begin
        m_dir = !m_dir;
        m_out = m_dir ? sat_up(m_out) : sat_dn(m_out);
      end else if (m_dir && (m_out == max)) begin
        m_dir = 1'b0;
        m_out = sat_dn(max);
      end else if (!m_dir && (m_out == min)) begin
        m_dir = 1'b1;
        m_out = sat_up(min);
      end else begin
        m_out = m_dir ? sat_up(m_out) : sat_dn(m_out);
      end
    end else if (mode == 2'b01) begin
      m_dir = 1'b1;
      m_out = (m_out == max) ? min : sat_up(m_out);
    end else begin
      m_dir = 1'b0;
      m_out = (m_out == min) ? max : sat_dn(m_out);
    end
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic cyc();
    exp_t e;
    model_step();
    e.out = m_out;
    e.dir = m_dir;
    e.re  = (min >= max);
    e.ab  = !e.re && ((m_out == min) || (m_out == max));
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      chk("sb_out", 8'(out), 8'(e.out));
      chk("sb_dir", 8'(direction), 8'(e.dir));
      chk("sb_at_bound", 8'(at_bound), 8'(e.ab));
      chk("sb_range_err", 8'(range_err), 8'(e.re));
    end
  endtask

  task automatic run_seq(input string tag);
    foreach (seq[i]) begin
      cyc();
      chk(tag, 8'(out), 8'(seq[i]));
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'b00; min = 4'd3; max = 4'd12; step = 4'd1;
    flip = 1'b0; load = 1'b0; load_val = 4'd0;
    m_out = 4'd0; m_dir = 1'b1;
    #1;
    chk("reset_out", 8'(out), 8'd0);
    chk("reset_dir", 8'(direction), 8'd1);
    chk("reset_at_bound", 8'(at_bound), 8'd0);
    chk("reset_range_err", 8'(range_err), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;

    // Ping-pong, step 1: recentre to 3, sweep up to 12, down to 3, back to 4
    seq.delete();
    for (int v = 3; v <= 12; v++) seq.push_back(v);
    for (int v = 11; v >= 3; v--) seq.push_back(v);
    seq.push_back(4);
    run_seq("t1_out");
    chk("t1_dir_end", 8'(direction), 8'd1);

    // Ping-pong, step 4
    load = 1'b1; load_val = 4'd3; cyc(); load = 1'b0;
    step = 4'd4;
    seq = '{7, 11, 12, 8, 4, 3, 7};
    run_seq("t2_out");

    // Flip while counting up at 6, then flip masked by enable=0
    step = 4'd1;
    load = 1'b1; load_val = 4'd5; cyc(); load = 1'b0;
    cyc();
    chk("t3_at6", 8'(out), 8'd6);
    flip = 1'b1; cyc(); flip = 1'b0;
    chk("t3_flip_out", 8'(out), 8'd5);
    chk("t3_flip_dir", 8'(direction), 8'd0);
    seq = '{4, 3, 4};
    run_seq("t3_out");
    enable = 1'b0; flip = 1'b1;
    seq = '{4, 4, 4};
    run_seq("t3_hold");
    enable = 1'b1; flip = 1'b0;

    // Wrap-up across full WIDTH range, then wrap-down
    mode = 2'b01; min = 4'd0; max = 4'd15; step = 4'd3;
    load = 1'b1; load_val = 4'd12; cyc(); load = 1'b0;
    seq = '{15, 0, 3};
    run_seq("t4_wrap_up");
    mode = 2'b10;
    load = 1'b1; load_val = 4'd2; cyc(); load = 1'b0;
    seq = '{0, 15, 12};
    run_seq("t4_wrap_dn");
    chk("t4_dir", 8'(direction), 8'd0);

    // Invalid range holds, then recentre and tight ping-pong
    load = 1'b1; load_val = 4'd3; cyc(); load = 1'b0;
    mode = 2'b00; step = 4'd1; min = 4'd8; max = 4'd2;
    seq = '{3, 3, 3, 3, 3};
    run_seq("t5_hold");
    chk("t5_range_err", 8'(range_err), 8'd1);
    min = 4'd7; max = 4'd15;
    cyc();
    chk("t5_recentre_out", 8'(out), 8'd7);
    chk("t5_recentre_dir", 8'(direction), 8'd1);
    max = 4'd8;
    seq = '{8, 7, 8};
    run_seq("t5_alt");

    // Asynchronous reset between edges, then load with enable low
    #3;
    rst = 1'b1;
    #1;
    m_out = 4'd0; m_dir = 1'b1;
    chk("t6_rst_out", 8'(out), 8'd0);
    chk("t6_rst_dir", 8'(direction), 8'd1);
    #2;
    rst = 1'b0; enable = 1'b0; load = 1'b1; load_val = 4'd9;
    cyc();
    chk("t6_load", 8'(out), 8'd9);
    load = 1'b0;
    seq = '{9, 9, 9};
    run_seq("t6_hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
